// File: rtl/vga_pkg.sv
// Shared constants and types for the 1280x1024@60 test-pattern generator:
// raster timing, pattern modes, colour table and pipeline stage layout.
package vga_pkg;

  // 1280x1024@60, 108 MHz pixel clock
  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 48;
  localparam int H_SYNC   = 112;
  localparam int H_BP     = 248;
  localparam int H_TOTAL  = 1688;
  localparam int V_ACTIVE = 1024;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 3;
  localparam int V_BP     = 38;
  localparam int V_TOTAL  = 1066;

  localparam int BOX_SIZE = 64;
  localparam int STEP     = 2;
  localparam int BAR_W    = 160;

  typedef enum logic [1:0] {
    MODE_WHITE   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BOX     = 2'd3
  } mode_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COL_WHITE = 12'hFFF;
  localparam rgb_t COL_BLACK = 12'h000;
  localparam rgb_t COL_BLUE  = 12'h00F;

  // Element 0 is the leftmost bar.
  localparam logic [7:0][11:0] BAR_TABLE = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] h;
    logic [10:0] v;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, h: '0, v: '0};

  typedef struct packed {
    logic [10:0] pos;
    logic        dir;   // 1 = increasing
  } axis_t;

  // Compare chain instead of a divider; anything past the last bar maps to 7.
  function automatic logic [2:0] bar_index(input logic [10:0] h);
    bar_index = 3'd7;
    for (int i = 6; i >= 0; i--)
      if (h < 11'((i + 1) * BAR_W)) bar_index = 3'(i);
  endfunction

  // One bounce step along an axis; limit is the largest legal position.
  function automatic axis_t axis_step(input axis_t a, input logic [11:0] limit);
    axis_t n;
    n = a;
    if (a.dir) begin
      if ({1'b0, a.pos} + 12'(STEP) >= limit) begin
        n.pos = limit[10:0];
        n.dir = 1'b0;
      end else begin
        n.pos = a.pos + 11'(STEP);
      end
    end else begin
      if (a.pos <= 11'(STEP)) begin
        n.pos = '0;
        n.dir = 1'b1;
      end else begin
        n.pos = a.pos - 11'(STEP);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: advances one step per frame start on both axes,
// reflecting off the active-area edges.
module vga_box_mover
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  output logic [10:0] bx,
  output logic [10:0] by
);

  localparam logic [11:0] X_LIMIT = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0] Y_LIMIT = 12'(V_ACTIVE - BOX_SIZE);

  axis_t x_q, y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '{pos: '0, dir: 1'b1};
      y_q <= '{pos: '0, dir: 1'b1};
    end else if (frame_start) begin
      x_q <= axis_step(x_q, X_LIMIT);
      y_q <= axis_step(y_q, Y_LIMIT);
    end
  end

  assign bx = x_q.pos;
  assign by = y_q.pos;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: registers the upstream raster (stage 1), then
// computes the pixel colour and registers it with sync/DE (stage 2).
module vga_pattern_gen
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b
);

  logic        vs_q;
  mode_e       mode_q;
  logic        frame_start;
  logic [10:0] bx, by;
  stage_t      s1;
  rgb_t        pix, col_q;
  logic        in_box;
  logic [11:0] h12, v12, bx12, by12;

  assign frame_start = vs_q & ~vs_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q   <= 1'b1;
      mode_q <= MODE_WHITE;
    end else begin
      vs_q <= vs_in;
      if (frame_start) mode_q <= mode_e'(mode);
    end
  end

  vga_box_mover u_box (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .bx          (bx),
    .by          (by)
  );

  // Counters are zeroed outside active video so garbage never reaches the mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= STAGE_IDLE;
    end else begin
      s1.hs <= hs_in;
      s1.vs <= vs_in;
      s1.de <= de_in;
      s1.h  <= de_in ? hcount : '0;
      s1.v  <= de_in ? vcount : '0;
    end
  end

  // 12-bit so bx + BOX_SIZE cannot wrap.
  assign h12  = {1'b0, s1.h};
  assign v12  = {1'b0, s1.v};
  assign bx12 = {1'b0, bx};
  assign by12 = {1'b0, by};
  assign in_box = (h12 >= bx12) && (h12 < bx12 + 12'(BOX_SIZE)) &&
                  (v12 >= by12) && (v12 < by12 + 12'(BOX_SIZE));

  always_comb begin
    pix = COL_BLACK;
    case (mode_q)
      MODE_WHITE:   pix = COL_WHITE;
      MODE_BARS:    pix = rgb_t'(BAR_TABLE[bar_index(s1.h)]);
      MODE_CHECKER: pix = (s1.h[5] ^ s1.v[5]) ? COL_WHITE : COL_BLACK;
      MODE_BOX:     pix = in_box ? COL_WHITE : COL_BLUE;
      default:      pix = COL_BLACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
      col_q <= COL_BLACK;
    end else begin
      hsync <= s1.hs;
      vsync <= s1.vs;
      de    <= s1.de;
      col_q <= s1.de ? pix : COL_BLACK;
    end
  end

  assign r = col_q.r;
  assign g = col_q.g;
  assign b = col_q.b;

endmodule
